// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - memory-side request/acknowledge bus of mem_access_unit
interface mem_access_unit_if #(parameter int N = 32);
   logic         mem_req;
   logic         mem_we;
   logic [N-1:0] mem_addr;
   logic [N-1:0] mem_wdata;
   logic [3:0]   mem_be;
   logic         mem_ack;
   logic [N-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit: lane steering, alignment check, req/ack handshake
// Optional MEM_TIMEOUT_EN: abort WAIT after 255 cycles without mem_ack and pulse Timeout.
module mem_access_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         MemRead,
   input  logic         MemWrite,
   input  logic [1:0]   MemSize,
   input  logic         MemSigned,
   input  logic [N-1:0] Address,
   input  logic [N-1:0] Write_data,
   mem_access_unit_if.master mem,
   output logic [N-1:0] Read_data,
   output logic         Stall,
   output logic         Misaligned
`ifdef MEM_TIMEOUT_EN
   ,
   output logic         Timeout
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t       state_q, state_d;
   logic         mem_req_q, mem_req_d;
   logic         mem_we_q, mem_we_d;
   logic [N-1:0] mem_addr_q, mem_addr_d;
   logic [N-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]   mem_be_q, mem_be_d;
   logic [N-1:0] read_data_q, read_data_d;
   logic         misaligned_q, misaligned_d;
   logic [1:0]   lane_q, lane_d;
   logic [1:0]   size_q, size_d;
   logic         signed_q, signed_d;
   logic         is_load_q, is_load_d;
`ifdef MEM_TIMEOUT_EN
   logic [7:0]   cnt_q, cnt_d;
   logic         timeout_q, timeout_d;
`endif

   logic         access;
   logic         aligned;
   logic [3:0]   be_new;
   logic [N-1:0] wdata_new;

   function automatic logic [N-1:0] fmt_load(input logic [N-1:0] d, input logic [1:0] lane,
                                             input logic [1:0] size, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = lane[1] ? d[31:16] : d[15:0];
      case (size)
         2'b00:   fmt_load = sgn ? {{(N-8){b[7]}}, b} : {{(N-8){1'b0}}, b};
         2'b01:   fmt_load = sgn ? {{(N-16){h[15]}}, h} : {{(N-16){1'b0}}, h};
         default: fmt_load = d;
      endcase
   endfunction

   assign access  = MemRead | MemWrite;
   assign aligned = (MemSize == 2'b00) || (MemSize == 2'b01 && !Address[0]) ||
                    (Address[1:0] == 2'b00);

   always_comb begin
      case (MemSize)
         2'b00: begin
            be_new    = 4'b0001 << Address[1:0];
            wdata_new = {(N/8){Write_data[7:0]}};
         end
         2'b01: begin
            be_new    = Address[1] ? 4'b1100 : 4'b0011;
            wdata_new = {(N/16){Write_data[15:0]}};
         end
         default: begin
            be_new    = 4'b1111;
            wdata_new = Write_data;
         end
      endcase
   end

   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      read_data_d  = read_data_q;
      misaligned_d = 1'b0;
      lane_d       = lane_q;
      size_d       = size_q;
      signed_d     = signed_q;
      is_load_d    = is_load_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d        = cnt_q;
      timeout_d    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (access) begin
               if (aligned) begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = MemWrite;
                  mem_addr_d  = {Address[N-1:2], 2'b00};
                  mem_wdata_d = wdata_new;
                  mem_be_d    = be_new;
                  lane_d      = Address[1:0];
                  size_d      = MemSize;
                  signed_d    = MemSigned;
                  // a simultaneous MemRead is dropped: the store wins
                  is_load_d   = !MemWrite;
`ifdef MEM_TIMEOUT_EN
                  cnt_d       = 8'd0;
`endif
                  state_d     = WAIT;
               end else begin
                  misaligned_d = 1'b1;
                  read_data_d  = '0;
               end
            end
         end
         WAIT: begin
            if (mem.mem_ack) begin
               mem_req_d = 1'b0;
               if (is_load_q) read_data_d = fmt_load(mem.mem_rdata, lane_q, size_q, signed_q);
               state_d   = DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == 8'd254) begin
               mem_req_d   = 1'b0;
               timeout_d   = 1'b1;
               read_data_d = '0;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= 4'b0000;
         read_data_q  <= '0;
         misaligned_q <= 1'b0;
         lane_q       <= 2'b00;
         size_q       <= 2'b00;
         signed_q     <= 1'b0;
         is_load_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_q        <= 8'd0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
         read_data_q  <= read_data_d;
         misaligned_q <= misaligned_d;
         lane_q       <= lane_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         is_load_q    <= is_load_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q        <= cnt_d;
         timeout_q    <= timeout_d;
`endif
      end
   end

   // reset gates Stall so a request held during reset does not freeze the pipeline
   assign Stall = reset && (((state_q == IDLE) && access && aligned) || (state_q == WAIT));

   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;
   assign mem.mem_be    = mem_be_q;
   assign Read_data     = read_data_q;
   assign Misaligned    = misaligned_q;
`ifdef MEM_TIMEOUT_EN
   assign Timeout       = timeout_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit (define MEM_TIMEOUT_EN to cover timeout)
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemRead = 1'b0, MemWrite = 1'b0, MemSigned = 1'b0;
   logic [1:0]  MemSize = 2'b00;
   logic [31:0] Address = '0, Write_data = '0;
   logic [31:0] Read_data;
   logic        Stall, Misaligned;
`ifdef MEM_TIMEOUT_EN
   logic        Timeout;
`endif

   always #5 clk = ~clk;

   mem_access_unit_if #(.N(32)) bus ();

   mem_access_unit #(.N(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .MemSize    (MemSize),
      .MemSigned  (MemSigned),
      .Address    (Address),
      .Write_data (Write_data),
      .mem        (bus.master),
      .Read_data  (Read_data),
      .Stall      (Stall),
      .Misaligned (Misaligned)
`ifdef MEM_TIMEOUT_EN
      ,
      .Timeout    (Timeout)
`endif
   );

   int          n_cmp = 0, n_fail = 0;
   logic [31:0] rd_model = '0;

   int          o_stall, o_req, o_to;
   logic        o_we, o_stable, o_mis1, o_mis2;
   logic [31:0] o_addr, o_wdata, o_rd;
   logic [3:0]  o_be;

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
      int off = int'(a % 4);
      if (sz == 2'd0) return 4'(1 << off);
      if (sz == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
      if (sz == 2'd0) return (wd & 32'hFF) * 32'h01010101;
      if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
      return wd;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] d, input logic [1:0] sz,
                                          input logic sg, input logic [31:0] a);
      logic [31:0] v;
      int off = int'(a % 4);
      if (sz == 2'd0) begin
         v = (d >> (8 * off)) & 32'hFF;
         if (sg && v >= 32'h80) v = v | 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
         v = (d >> (8 * (off & 2))) & 32'hFFFF;
         if (sg && v >= 32'h8000) v = v | 32'hFFFF0000;
      end else begin
         v = d;
      end
      return v;
   endfunction

   function automatic logic m_misal(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
   endfunction

   // Pipeline + memory emulation: holds the request until Stall drops, acks in the lat-th
   // WAIT cycle (lat=0 never acks), and records what the unit presented.
   task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                             input int lat);
      bit done = 0;
      @(negedge clk);
      MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg;
      Address = a; Write_data = wd; bus.mem_rdata = rdat; bus.mem_ack = 1'b0;
      o_stall = 0; o_req = 0; o_to = 0; o_stable = 1'b1;
      o_we = 1'b0; o_addr = '0; o_wdata = '0; o_be = '0;
      for (int k = 0; k < 400; k++) begin
         logic s;
         #1;
         s = Stall;
         if (s) o_stall++;
`ifdef MEM_TIMEOUT_EN
         if (Timeout) o_to++;
`endif
         if (bus.mem_req) begin
            if (o_req == 0) begin
               o_we = bus.mem_we; o_addr = bus.mem_addr; o_wdata = bus.mem_wdata; o_be = bus.mem_be;
            end else if (o_we !== bus.mem_we || o_addr !== bus.mem_addr ||
                         o_wdata !== bus.mem_wdata || o_be !== bus.mem_be) begin
               o_stable = 1'b0;
            end
            o_req++;
            bus.mem_ack = (lat > 0 && o_req >= lat);
         end else begin
            bus.mem_ack = 1'b0;
         end
         @(posedge clk);
         if (!s) begin
            done = 1;
            break;
         end
      end
      if (!done) begin
         n_cmp++; n_fail++;
         $display("FAIL access_bound: Stall still high after 400 cycles, required release");
      end
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0; bus.mem_ack = 1'b0;
      #1;
      o_mis1 = Misaligned; o_rd = Read_data;
      @(negedge clk);
      #1;
      o_mis2 = Misaligned;
   endtask

   task automatic test_reset();
      MemRead = 1'b1; MemSize = 2'd2; Address = 32'h40;
      #1;
      n_cmp++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, Read_data, Misaligned, Stall} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: req=%b we=%b addr=%h wd=%h be=%h rd=%h mis=%b stall=%b, required all 0",
                  bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, Read_data, Misaligned, Stall);
      end
      MemRead = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_lw();
      run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
      rd_model = 32'hDEADBEEF;
      n_cmp++;
      if ({o_be, o_addr, o_we} !== {4'hF, 32'h100, 1'b0}) begin
         n_fail++; $display("FAIL lw_request: be=%h addr=%h we=%b, required F/00000100/0", o_be, o_addr, o_we);
      end
      n_cmp++;
      if (o_stall !== 2) begin
         n_fail++; $display("FAIL lw_stall: %0d cycles, required 2", o_stall);
      end
      n_cmp++;
      if (o_rd !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL lw_data: %h, required DEADBEEF", o_rd);
      end
   endtask

   task automatic test_lb();
      run_access(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80123456, 1);
      n_cmp++;
      if ({o_be, o_rd} !== {4'b1000, 32'hFFFFFF80}) begin
         n_fail++; $display("FAIL lb_signed: be=%b rd=%h, required 1000/FFFFFF80", o_be, o_rd);
      end
      run_access(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80123456, 1);
      rd_model = 32'h00000080;
      n_cmp++;
      if ({o_be, o_rd} !== {4'b1000, 32'h00000080}) begin
         n_fail++; $display("FAIL lbu: be=%b rd=%h, required 1000/00000080", o_be, o_rd);
      end
   endtask

   task automatic test_sh();
      run_access(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 32'h11223344, 3);
      n_cmp++;
      if ({o_we, o_be, o_wdata, o_addr, o_stable} !== {1'b1, 4'b1100, 32'hABCDABCD, 32'h200, 1'b1}) begin
         n_fail++;
         $display("FAIL sh_request: we=%b be=%b wd=%h addr=%h stable=%b, required 1/1100/ABCDABCD/00000200/1",
                  o_we, o_be, o_wdata, o_addr, o_stable);
      end
      n_cmp++;
      if ({o_req, o_stall} !== {32'd3, 32'd4}) begin
         n_fail++; $display("FAIL sh_timing: req_cycles=%0d stall=%0d, required 3/4", o_req, o_stall);
      end
      n_cmp++;
      if (o_rd !== rd_model) begin
         n_fail++; $display("FAIL sh_keeps_rd: %h, required %h", o_rd, rd_model);
      end
   endtask

   task automatic test_write_priority();
      run_access(1'b1, 1'b1, 2'd2, 1'b0, 32'h380, 32'hCAFEF00D, 32'h55555555, 2);
      n_cmp++;
      if ({o_we, o_wdata, o_rd} !== {1'b1, 32'hCAFEF00D, rd_model}) begin
         n_fail++; $display("FAIL write_priority: we=%b wd=%h rd=%h, required 1/CAFEF00D/%h", o_we, o_wdata, o_rd, rd_model);
      end
   endtask

   task automatic test_misaligned();
      run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h12345678, 1);
      rd_model = '0;
      n_cmp++;
      if ({o_req, o_stall} !== {32'd0, 32'd0}) begin
         n_fail++; $display("FAIL misaligned_noreq: req_cycles=%0d stall=%0d, required 0/0", o_req, o_stall);
      end
      n_cmp++;
      if ({o_mis1, o_mis2, o_rd} !== {1'b1, 1'b0, 32'h0}) begin
         n_fail++; $display("FAIL misaligned_pulse: pulse=%b%b rd=%h, required 10/00000000", o_mis1, o_mis2, o_rd);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         logic [1:0]  sz = 2'($urandom_range(0, 3));
         logic [31:0] a = $urandom;
         logic [31:0] wd = $urandom;
         logic [31:0] rdat = $urandom;
         logic        sg = 1'($urandom_range(0, 1));
         logic        wr = 1'($urandom_range(0, 1));
         logic        rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         int          lat = $urandom_range(1, 4);
         if (i % 4 == 0) a[1:0] = 2'b00;
         run_access(rd, wr, sz, sg, a, wd, rdat, lat);
         if (m_misal(sz, a)) begin
            rd_model = '0;
            n_cmp++;
            if ({o_req, o_stall, o_mis1, o_mis2, o_rd} !== {32'd0, 32'd0, 1'b1, 1'b0, rd_model}) begin
               n_fail++;
               $display("FAIL rand_misal[%0d]: sz=%0d a=%h req=%0d stall=%0d mis=%b%b rd=%h, required 0/0/10/%h",
                        i, sz, a, o_req, o_stall, o_mis1, o_mis2, o_rd, rd_model);
            end
         end else begin
            if (!wr) rd_model = m_load(rdat, sz, sg, a);
            n_cmp++;
            if ({o_req, o_stall, o_addr, o_be, o_we, o_stable, o_mis1, o_rd} !==
                {lat, lat + 1, a & 32'hFFFFFFFC, m_be(sz, a), wr, 1'b1, 1'b0, rd_model}) begin
               n_fail++;
               $display("FAIL rand_access[%0d]: sz=%0d a=%h lat=%0d got req=%0d stall=%0d addr=%h be=%h we=%b stable=%b mis=%b rd=%h, required rd=%h be=%h",
                        i, sz, a, lat, o_req, o_stall, o_addr, o_be, o_we, o_stable, o_mis1, o_rd,
                        rd_model, m_be(sz, a));
            end
            if (wr) begin
               n_cmp++;
               if (o_wdata !== m_wdata(sz, wd)) begin
                  n_fail++; $display("FAIL rand_wdata[%0d]: %h, required %h", i, o_wdata, m_wdata(sz, wd));
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      logic bad = 1'b0;
      @(negedge clk);
      MemRead = 1'b1; MemWrite = 1'b0; MemSize = 2'd2; Address = 32'h300; bus.mem_ack = 1'b0;
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.mem_req !== 1'b1) begin
         n_fail++; $display("FAIL midwait_setup: mem_req=%b, required 1", bus.mem_req);
      end
      #1;
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, Read_data, Misaligned, Stall} !== '0) begin
         n_fail++;
         $display("FAIL midwait_reset: req=%b addr=%h be=%h rd=%h stall=%b, required all 0",
                  bus.mem_req, bus.mem_addr, bus.mem_be, Read_data, Stall);
      end
      MemRead = 1'b0;
      rd_model = '0;
      @(negedge clk);
      reset = 1'b1;
      bus.mem_ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (bus.mem_req !== 1'b0 || Stall !== 1'b0 || Read_data !== 32'h0) bad = 1'b1;
      end
      bus.mem_ack = 1'b0;
      n_cmp++;
      if (bad) begin
         n_fail++; $display("FAIL stray_ack: stray mem_ack changed outputs (bad=%b), required 0", bad);
      end
      run_access(1'b1, 1'b0, 2'd1, 1'b1, 32'h306, 32'h0, 32'h9ABC1234, 1);
      rd_model = 32'hFFFF9ABC;
      n_cmp++;
      if ({o_stall, o_rd} !== {32'd2, rd_model}) begin
         n_fail++; $display("FAIL after_reset_access: stall=%0d rd=%h, required 2/%h", o_stall, o_rd, rd_model);
      end
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h77777777, 0);
      rd_model = '0;
      n_cmp++;
      if ({o_req, o_stall, o_to, o_rd} !== {32'd255, 32'd256, 32'd1, 32'h0}) begin
         n_fail++;
         $display("FAIL timeout: req_cycles=%0d stall=%0d pulses=%0d rd=%h, required 255/256/1/00000000",
                  o_req, o_stall, o_to, o_rd);
      end
   endtask
`endif

   initial begin
      bus.mem_ack = 1'b0;
      bus.mem_rdata = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_lw();
      test_lb();
      test_sh();
      test_write_priority();
      test_misaligned();
      test_random();
      test_reset_mid_wait();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
